// File: rtl/real_adder_arbiter_if.sv
// real_adder_arbiter_if
// Bundles everything that passes between the requesters, the shared BBFAdd
// instance and the result consumer.
//   req_valid/req_ready   per-requester handshake (NREQ bits each)
//   req_a/req_b           packed operand pairs, requester i at [i*WIDTH +: WIDTH]
//   add_in1/add_in2       operands to the shared adder
//   add_out               combinational sum returned by the adder
//   rsp_valid/rsp_ready   result handshake
//   rsp_data/rsp_id       registered sum and the index of its requester
// slave  : the arbiter's view
// master : the environment's view (requesters, adder, consumer)
interface real_adder_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 64,
  parameter int IDW   = 2
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [WIDTH-1:0]      add_in1;
  logic [WIDTH-1:0]      add_in2;
  logic [WIDTH-1:0]      add_out;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [WIDTH-1:0]      rsp_data;
  logic [IDW-1:0]        rsp_id;

  modport slave (
    input  req_valid, req_a, req_b, add_out, rsp_ready,
    output req_ready, add_in1, add_in2, rsp_valid, rsp_data, rsp_id
  );

  modport master (
    output req_valid, req_a, req_b, add_out, rsp_ready,
    input  req_ready, add_in1, add_in2, rsp_valid, rsp_data, rsp_id
  );
endinterface

// File: rtl/real_adder_arbiter.sv
// real_adder_arbiter
// Round-robin arbiter sharing one combinational 64-bit floating-point adder
// between NREQ requesters. The winner's operands drive the adder and the sum
// is captured into a one-entry result register tagged with the winner index.
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous, active-high
//   bus       real_adder_arbiter_if.slave (requests, adder, result)
//   op_count  number of issued operations, wraps modulo 2^CNTW
module real_adder_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 64,
  parameter int IDW   = 2,
  parameter int CNTW  = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  real_adder_arbiter_if.slave     bus,
  output logic [CNTW-1:0]         op_count
);

  logic [IDW-1:0]    rr_ptr_reg;
  logic              rsp_valid_reg;
  logic [WIDTH-1:0]  rsp_data_reg;
  logic [IDW-1:0]    rsp_id_reg;
  logic [CNTW-1:0]   op_count_reg;

  logic [WIDTH-1:0]  a_arr [NREQ];
  logic [WIDTH-1:0]  b_arr [NREQ];

  logic              can_issue;
  logic              grant_valid;
  logic [2*NREQ-1:0] req_dbl;
  logic [NREQ-1:0]   req_rot;
  logic [IDW-1:0]    offset;
  logic [IDW:0]      grant_sum;
  logic [IDW-1:0]    grant_idx;
  logic [IDW:0]      ptr_inc;
  logic [IDW-1:0]    rr_ptr_next;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign a_arr[gi] = bus.req_a[gi*WIDTH +: WIDTH];
      assign b_arr[gi] = bus.req_b[gi*WIDTH +: WIDTH];
    end
  endgenerate

  assign can_issue   = !rsp_valid_reg || bus.rsp_ready;
  assign grant_valid = can_issue && (|bus.req_valid);

  // Rotate the request vector so that bit 0 is the rr_ptr requester; the
  // first set bit of the rotated vector is then the winner's distance from
  // rr_ptr.
  assign req_dbl = {bus.req_valid, bus.req_valid};
  assign req_rot = NREQ'(req_dbl >> rr_ptr_reg);

  always_comb begin
    offset = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        offset = IDW'(k);
      end
    end
    // rr_ptr and offset are both below NREQ, so one subtraction wraps.
    grant_sum = {1'b0, rr_ptr_reg} + {1'b0, offset};
    if (grant_sum >= (IDW+1)'(NREQ)) begin
      grant_sum = grant_sum - (IDW+1)'(NREQ);
    end
    grant_idx = grant_sum[IDW-1:0];

    ptr_inc = {1'b0, grant_idx} + (IDW+1)'(1);
    if (ptr_inc == (IDW+1)'(NREQ)) begin
      rr_ptr_next = '0;
    end else begin
      rr_ptr_next = ptr_inc[IDW-1:0];
    end
  end

  always_comb begin
    bus.req_ready = '0;
    bus.add_in1   = '0;
    bus.add_in2   = '0;
    if (grant_valid) begin
      bus.req_ready[grant_idx] = 1'b1;
      bus.add_in1              = a_arr[grant_idx];
      bus.add_in2              = b_arr[grant_idx];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_reg    <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_data_reg  <= '0;
      rsp_id_reg    <= '0;
      op_count_reg  <= '0;
    end else if (grant_valid) begin
      // A fire overwrites any result being drained in the same cycle.
      rsp_data_reg  <= bus.add_out;
      rsp_id_reg    <= grant_idx;
      rsp_valid_reg <= 1'b1;
      rr_ptr_reg    <= rr_ptr_next;
      op_count_reg  <= op_count_reg + CNTW'(1);
    end else if (rsp_valid_reg && bus.rsp_ready) begin
      rsp_valid_reg <= 1'b0;
    end
  end

  assign bus.rsp_valid = rsp_valid_reg;
  assign bus.rsp_data  = rsp_data_reg;
  assign bus.rsp_id    = rsp_id_reg;
  assign op_count      = op_count_reg;

endmodule

// File: tb/tb_real_adder_arbiter.sv
// tb_real_adder_arbiter
// Directed bench for real_adder_arbiter with a behavioural model of the
// arbitration/result rules and a real-arithmetic stand-in for BBFAdd.
module tb_real_adder_arbiter;
  localparam int NREQ  = 4;
  localparam int WIDTH = 64;
  localparam int IDW   = 2;
  localparam int CNTW  = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [CNTW-1:0] op_count;

  real_adder_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) bus ();

  always #5 clk = ~clk;

  // Shared adder stand-in.
  assign bus.add_out = $realtobits($bitstoreal(bus.add_in1) + $bitstoreal(bus.add_in2));

  real_adder_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW), .CNTW(CNTW)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus.slave),
    .op_count (op_count)
  );

  int n_vec = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;
  int seq = 0;

  // Model state.
  int          m_ptr   = 0;
  bit          m_valid = 1'b0;
  logic [63:0] m_data  = '0;
  int          m_id    = 0;
  int          m_cnt   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] op_a(input int i);
    return bus.req_a[i*WIDTH +: WIDTH];
  endfunction

  function automatic logic [63:0] op_b(input int i);
    return bus.req_b[i*WIDTH +: WIDTH];
  endfunction

  function automatic logic [63:0] fadd(input logic [63:0] a, input logic [63:0] b);
    return $realtobits($bitstoreal(a) + $bitstoreal(b));
  endfunction

  // Winner under the round-robin rule, or -1 when nothing may issue.
  function automatic int model_grant();
    if (m_valid && !bus.rsp_ready) return -1;
    for (int k = 0; k < NREQ; k++) begin
      if (bus.req_valid[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    end
    return -1;
  endfunction

  always @(posedge clk or posedge reset) begin
    int g;
    if (reset) begin
      m_ptr = 0; m_valid = 1'b0; m_data = '0; m_id = 0; m_cnt = 0;
    end else begin
      g = model_grant();
      if (g >= 0) begin
        m_data  = fadd(op_a(g), op_b(g));
        m_id    = g;
        m_valid = 1'b1;
        m_ptr   = (g + 1) % NREQ;
        m_cnt   = (m_cnt + 1) % (1 << CNTW);
      end else if (m_valid && bus.rsp_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    int g;
    logic [NREQ-1:0] exp_rdy;
    if (cmp_en && !reset) begin
      g = model_grant();
      exp_rdy = (g >= 0) ? NREQ'(1 << g) : '0;
      check("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
      check("add_in1", bus.add_in1, (g >= 0) ? op_a(g) : 64'd0);
      check("add_in2", bus.add_in2, (g >= 0) ? op_b(g) : 64'd0);
      check("rsp_valid", 64'(bus.rsp_valid), 64'(m_valid));
      if (m_valid) begin
        check("rsp_data", bus.rsp_data, m_data);
        check("rsp_id", 64'(bus.rsp_id), 64'(m_id));
      end
      check("op_count", 64'(op_count), 64'(m_cnt));
    end
  end

  task automatic set_ops(input int i, input int n);
    bus.req_a[i*WIDTH +: WIDTH] = $realtobits(real'(n) + 0.5);
    bus.req_b[i*WIDTH +: WIDTH] = $realtobits(real'(i) * 2.25 + 1.0);
  endtask

  // One cycle: sample req_ready mid-cycle, pass the edge, then retire or
  // refill every requester that was accepted. Returns at posedge + 1.
  task automatic step(input bit refill, output logic [NREQ-1:0] rdy);
    @(negedge clk);
    rdy = bus.req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (rdy[i]) begin
        if (refill) begin
          seq++;
          set_ops(i, seq);
        end else begin
          bus.req_valid[i] = 1'b0;
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NREQ-1:0] rdy;
    logic [NREQ-1:0] rr_exp [5];
    rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    reset         = 1'b1;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("reset_op_count", 64'(op_count), 64'd0);
    check("reset_req_ready", 64'(bus.req_ready), 64'd0);
    reset  = 1'b0;
    cmp_en = 1'b1;

    // Single request: 1.0 + 2.0.
    bus.req_a[0 +: WIDTH] = 64'h3FF0000000000000;
    bus.req_b[0 +: WIDTH] = 64'h4000000000000000;
    bus.req_valid = 4'b0001;
    step(1'b0, rdy);
    check("single_grant", 64'(rdy), 64'(4'b0001));
    check("single_valid", 64'(bus.rsp_valid), 64'd1);
    check("single_data", bus.rsp_data, 64'h4008000000000000);
    check("single_id", 64'(bus.rsp_id), 64'd0);
    check("single_count", 64'(op_count), 64'd1);

    // Lone req3 brings the pointer back round to 0.
    set_ops(3, 100);
    bus.req_valid = 4'b1000;
    step(1'b0, rdy);
    check("req3_grant", 64'(rdy), 64'(4'b1000));

    // All four continuously valid.
    for (int i = 0; i < NREQ; i++) set_ops(i, 10 + i);
    bus.req_valid = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      step(1'b1, rdy);
      check("rr_grant", 64'(rdy), 64'(rr_exp[n]));
      check("rr_busy", 64'(bus.rsp_valid), 64'd1);
    end
    bus.req_valid = '0;
    check("rr_last_id", 64'(bus.rsp_id), 64'd0);

    // Wrap priority: grant 1, then req0 and req3 compete from rr_ptr = 2.
    set_ops(1, 200);
    bus.req_valid = 4'b0010;
    step(1'b0, rdy);
    check("wrap_g1", 64'(rdy), 64'(4'b0010));
    set_ops(0, 201);
    set_ops(3, 202);
    bus.req_valid = 4'b1001;
    step(1'b0, rdy);
    check("wrap_g3", 64'(rdy), 64'(4'b1000));
    step(1'b0, rdy);
    check("wrap_g0", 64'(rdy), 64'(4'b0001));

    // Backpressure on the req0 result while req1 waits.
    bus.rsp_ready = 1'b0;
    set_ops(1, 300);
    bus.req_valid = 4'b0010;
    for (int n = 0; n < 3; n++) begin
      step(1'b0, rdy);
      check("bp_ready", 64'(rdy), 64'd0);
      check("bp_id", 64'(bus.rsp_id), 64'd0);
      check("bp_data", bus.rsp_data, fadd(op_a(0), op_b(0)));
    end
    bus.rsp_ready = 1'b1;
    step(1'b0, rdy);
    check("bp_release", 64'(rdy), 64'(4'b0010));
    check("bp_new_valid", 64'(bus.rsp_valid), 64'd1);
    check("bp_new_id", 64'(bus.rsp_id), 64'd1);

    // Asynchronous reset between edges with a result pending.
    @(negedge clk);
    #2;
    reset = 1'b1;
    set_ops(2, 400);
    bus.req_valid = 4'b0100;
    #1;
    check("arst_valid", 64'(bus.rsp_valid), 64'd0);
    check("arst_data", bus.rsp_data, 64'd0);
    check("arst_id", 64'(bus.rsp_id), 64'd0);
    check("arst_count", 64'(op_count), 64'd0);
    check("arst_ready", 64'(bus.req_ready), 64'(4'b0100));
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    bus.req_valid = '0;
    check("arst_after_valid", 64'(bus.rsp_valid), 64'd1);
    check("arst_after_id", 64'(bus.rsp_id), 64'd2);
    check("arst_after_data", bus.rsp_data, fadd(op_a(2), op_b(2)));
    check("arst_after_count", 64'(op_count), 64'd1);

    // Counter wrap: 17 operations from reset on a 4-bit counter.
    @(negedge clk);
    #2;
    reset = 1'b1;
    #2;
    reset = 1'b0;
    @(posedge clk);
    #1;
    set_ops(0, 500);
    bus.req_valid = 4'b0001;
    for (int n = 0; n < 17; n++) begin
      step(1'b1, rdy);
    end
    bus.req_valid = '0;
    check("wrap_count", 64'(op_count), 64'd1);

    repeat (2) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
